// File: rtl/serial_subtractor.sv
// Digit-serial ripple-borrow subtractor: diff = a - b - bin, DIGIT bits per clock,
// least significant digit first, with a start/done handshake.

module serial_subtractor_fs (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_subtractor: illegal WIDTH/DIGIT combination");
  end

  logic [1:0]             state;
  logic [WIDTH-1:0]       a_sh, b_sh, acc;
  logic                   borrow, a_msb, b_msb;
  logic [CW-1:0]          cnt;
  logic [DIGIT:0]         bc;
  logic [DIGIT-1:0]       d;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [WIDTH-1:0]       acc_nx;
  logic                   last;

  // One digit of chained full-subtractor slices fed by the borrow flop
  assign bc[0] = borrow;
  for (genvar i = 0; i < DIGIT; i++) begin : g_slice
    serial_subtractor_fs u_fs (
      .x (a_sh[i]),
      .y (b_sh[i]),
      .bi(bc[i]),
      .d (d[i]),
      .bo(bc[i+1])
    );
  end

  // New digit enters at the top; after STEPS shifts the word is aligned
  assign cat    = {d, acc};
  assign acc_nx = cat[WIDTH+DIGIT-1:DIGIT];
  assign last   = (cnt == CW'(STEPS - 1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
            cnt    <= '0;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          borrow <= bc[DIGIT];
          acc    <= acc_nx;
          cnt    <= cnt + 1'b1;
          if (last) begin
            diff  <= acc_nx;
            bout  <= bc[DIGIT];
            ovf   <= (a_msb ^ b_msb) & (acc_nx[WIDTH-1] ^ a_msb);
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, random operands and an
// exhaustive WIDTH=4 sweep over DIGIT=1,2,4, all against an arithmetic reference.

module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       bin = 1'b0;

  logic       busy, done, bout, ovf;
  logic [7:0] diff;
  logic       busy84, done84, bout84, ovf84;
  logic [7:0] diff84;
  logic       busy4 [3], done4 [3], bout4 [3], ovf4 [3];
  logic [3:0] diff4 [3];

  int errors = 0;
  int checks = 0;
  int k4 [3];
  logic [9:0] r4 [3];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut84 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy84), .done(done84), .diff(diff84), .bout(bout84), .ovf(ovf84)
  );

  for (genvar g = 0; g < 3; g++) begin : g_w4
    serial_subtractor #(.WIDTH(4), .DIGIT(1 << g)) u (
      .clk(clk), .rst(rst), .start(start), .a(a[3:0]), .b(b[3:0]), .bin(bin),
      .busy(busy4[g]), .done(done4[g]), .diff(diff4[g]), .bout(bout4[g]), .ovf(ovf4[g])
    );
  end

  // Reference: {ovf, bout, diff zero-extended to 8 bits} from plain integer arithmetic
  function automatic logic [9:0] model(input int ma, input int mb, input int mbin, input int w);
    int half, full, dd, sa, sb, sd;
    logic [9:0] r;
    half = 1 << (w - 1);
    full = 1 << w;
    dd   = ma - mb - mbin;
    sa   = (ma >= half) ? ma - full : ma;
    sb   = (mb >= half) ? mb - full : mb;
    sd   = sa - sb - mbin;
    r      = '0;
    r[7:0] = 8'(dd & (full - 1));
    r[8]   = (dd < 0);
    r[9]   = (sd < -half) || (sd > half - 1);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation on the WIDTH=8 DUTs; DIGIT=4 copy runs alongside
  task automatic op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin);
    int k, k84, nbusy;
    logic [9:0] exp, got84;
    @(negedge clk); a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(negedge clk); start = 1'b0;
    nbusy = busy ? 1 : 0;
    k = 0; k84 = -1; got84 = 'x;
    if (done84) begin k84 = 0; got84 = {ovf84, bout84, diff84}; end
    while (k < 20 && !done) begin
      @(negedge clk); k++;
      if (busy) nbusy++;
      if (done84 && k84 < 0) begin k84 = k; got84 = {ovf84, bout84, diff84}; end
    end
    exp = model(ta, tb_, tbin, 8);
    chk("latency", k + 1, 9);
    chk("busy_cycles", nbusy, 8);
    chk("result", {ovf, bout, diff}, exp);
    chk("latency_d4", k84 + 1, 3);
    chk("result_d4", got84, exp);
    @(negedge clk);
    chk("done_single", done, 1'b0);
  endtask

  initial begin
    int seen;
    logic [9:0] exp;

    // Reset and idle
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_diff", diff, 8'h00);
    chk("rst_bout", bout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0 || ovf !== 1'b0) seen = 1;
    end
    chk("idle_stable", seen, 0);

    // Basic, then outputs held while idle
    op(8'h05, 8'h03, 1'b0);
    chk("basic_diff", diff, 8'h02);
    repeat (5) @(negedge clk);
    chk("hold_diff", diff, 8'h02);
    chk("hold_done", done, 1'b0);

    // Borrow / overflow corners
    op(8'h00, 8'h01, 1'b0);
    chk("borrow_ff", {ovf, bout, diff}, {1'b0, 1'b1, 8'hFF});
    op(8'h80, 8'h01, 1'b0);
    chk("ovf_7f", {ovf, bout, diff}, {1'b1, 1'b0, 8'h7F});
    op(8'h10, 8'h0F, 1'b1);
    chk("bin_zero", {bout, diff}, {1'b0, 8'h00});
    op(8'h7F, 8'hFF, 1'b0);
    chk("ovf_80", {ovf, bout, diff}, {1'b1, 1'b1, 8'h80});

    // Random operands
    repeat (16) op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

    // Handshake: start held, operands changed mid-run, back-to-back accept in DONE
    @(negedge clk); a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) begin a = 8'h40; b = 8'h10; end
    end
    chk("hs_done1", done, 1'b1);
    chk("hs_diff1", diff, 8'h02);
    @(negedge clk);
    chk("hs_b2b_busy", busy, 1'b1);
    chk("hs_b2b_done", done, 1'b0);
    start = 1'b0;
    for (int k = 10; k <= 17; k++) begin
      @(negedge clk);
      if (k == 12) chk("hs_diff_held", diff, 8'h02);
    end
    chk("hs_done2", done, 1'b1);
    chk("hs_diff2", {ovf, bout, diff}, {1'b0, 1'b0, 8'h30});

    // Reset mid-operation
    @(negedge clk); a = 8'h55; b = 8'h22; bin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_out", {ovf, bout, diff}, 10'h000);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    op(8'h55, 8'h22, 1'b0);
    chk("abort_recover", diff, 8'h33);

    // Exhaustive WIDTH=4 sweep across DIGIT=1,2,4
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          @(negedge clk); a = 8'(ia); b = 8'(ib); bin = 1'(ic); start = 1'b1;
          @(negedge clk); start = 1'b0;
          for (int g = 0; g < 3; g++) begin k4[g] = -1; r4[g] = 'x; end
          for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++)
              if (done4[g] && k4[g] < 0) begin
                k4[g] = k;
                r4[g] = {ovf4[g], bout4[g], 4'h0, diff4[g]};
              end
          end
          exp = model(ia, ib, ic, 4);
          for (int g = 0; g < 3; g++) begin
            chk($sformatf("w4_lat_d%0d", 1 << g), k4[g] + 1, (4 >> g) + 1);
            chk($sformatf("w4_res_d%0d_%0h_%0h_%0d", 1 << g, ia, ib, ic), r4[g], exp);
          end
        end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
